// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;

  typedef logic [XLEN-1:0] instr_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    instr_t          instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue with flush; head is read straight from the
// storage registers so decode never sees a combinational path from memory.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int           DEPTH     = 4,
  parameter fetch_entry_t RST_ENTRY = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           wr_entry,
  input  logic                   pop,
  output fetch_entry_t           rd_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    // A full queue may still accept a write when the head leaves this cycle.
    do_push  = push && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_ENTRY;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Decoupled fetch front end: credit-limited request issue, in-order response
// tagging, and redirect handling that flushes the queue and drops stale data.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int           CW        = $clog2(DEPTH) + 1;
  localparam fetch_entry_t RST_ENTRY = '{pc: RESET_PC, instr: '0};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [XLEN-1:0] target_pc;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_stale, q_push, q_pop;
  logic            q_full, q_empty;
  logic [CW-1:0]   q_count;
  fetch_entry_t    wr_entry, head;

  assign target_pc = redirect_pc & ~XLEN'(3);

  // outst_q counts live requests, drop_q counts stale ones still in flight;
  // together with the queue they can never exceed DEPTH.
  assign credit_used = {1'b0, q_count} + {1'b0, outst_q} + {1'b0, drop_q};

  assign imem_req_valid = reset_n && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_stale = (drop_q != '0);
  assign q_push    = imem_rsp_valid && !rsp_stale && !redirect_valid && (!q_full || q_pop);
  assign q_pop     = !q_empty && out_ready && !redirect_valid;

  assign wr_entry.pc    = rsp_pc_q;
  assign wr_entry.instr = imem_rsp_data;

  assign out_valid = !q_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      outst_d    = '0;
      // Every request still in flight is now stale, except one answered now.
      drop_d     = outst_q + drop_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (q_push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid && !rsp_stale);
      drop_d  = drop_q - CW'(imem_rsp_valid && rsp_stale);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH     (DEPTH),
    .RST_ENTRY (RST_ENTRY)
  ) u_queue (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (redirect_valid),
    .push     (q_push),
    .wr_entry (wr_entry),
    .pop      (q_pop),
    .rd_entry (head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: in-order memory model with per-request latency and
// an epoch-based reference of which instructions decode must receive.
module tb_fetch_prefetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  fetch_prefetch #(
    .XLEN     (32),
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  mreq_t       pend[$];
  ent_t        mq[$];
  int          epoch, cyc, last_due;
  logic [31:0] exp_fetch;
  int          n_vec, n_err;
  int          lat_min, lat_max, p_ordy, p_rrdy, p_redir;
  int          n_hs, n_acc, n_drop;
  bit          got_first;
  logic [31:0] first_pc, first_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_req_valid();
    return reset_n && !redirect_valid && ((mq.size() + pend.size()) < DEPTH);
  endfunction

  task automatic drive();
    redirect_valid = ($urandom_range(0, 99) < p_redir);
    redirect_pc    = 32'h0100_0000 | ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3);
    out_ready      = ($urandom_range(0, 99) < p_ordy);
    imem_req_ready = ($urandom_range(0, 99) < p_rrdy);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic check_req();
    bit v;
    v = model_req_valid();
    chk("req_valid", imem_req_valid, v);
    if (v) chk("req_addr", imem_req_addr, exp_fetch);
  endtask

  task automatic check_out();
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
    end
  endtask

  // Called with this cycle's inputs already applied; leaves the next cycle's
  // inputs applied and checked.
  task automatic cycle();
    bit          acc, pop, rsp, rdr;
    logic [31:0] tgt;
    mreq_t       r;
    int          d;
    acc = model_req_valid() && imem_req_ready;
    pop = (mq.size() != 0) && out_ready && !redirect_valid;
    rsp = imem_rsp_valid;
    rdr = redirect_valid;
    tgt = redirect_pc;
    @(posedge clock);
    #1;
    if (pop) begin
      n_hs++;
      if (!got_first) begin
        got_first   = 1'b1;
        first_pc    = mq[0].pc;
        first_instr = mq[0].instr;
      end
      void'(mq.pop_front());
    end
    if (rsp) begin
      r = pend.pop_front();
      if (!rdr && r.epoch == epoch) mq.push_back('{pc: r.addr, instr: mem_word(r.addr)});
      else n_drop++;
    end
    if (rdr) begin
      mq.delete();
      epoch++;
      exp_fetch = tgt & 32'hFFFF_FFFC;
    end
    if (acc) begin
      d = cyc + $urandom_range(lat_min, lat_max);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{addr: exp_fetch, epoch: epoch, due: d});
      exp_fetch = exp_fetch + 32'd4;
      n_acc++;
    end
    cyc++;
    @(negedge clock);
    check_out();
    drive();
    #1;
    check_req();
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b0;
    mq.delete();
    pend.delete();
    epoch++;
    exp_fetch = RST_PC;
    last_due  = cyc;
    n_acc     = 0;
    n_hs      = 0;
    n_drop    = 0;
    got_first = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, RST_PC);
    chk("rst_out_instr", out_instr, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    drive();
    #1;
    chk("rel_req_valid", imem_req_valid, !redirect_valid);
    check_req();
  endtask

  task automatic inject_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    #1;
    check_req();
  endtask

  task automatic set_mode(input int lmin, input int lmax, input int po, input int pr, input int pd);
    lat_min = lmin;
    lat_max = lmax;
    p_ordy  = po;
    p_rrdy  = pr;
    p_redir = pd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; epoch = 0; cyc = 0; last_due = 0;
    reset_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    exp_fetch = RST_PC;
    #1;

    // streaming with 1-cycle memory
    set_mode(1, 1, 100, 100, 0);
    do_reset();
    repeat (4) cycle();
    n_hs = 0;
    repeat (16) cycle();
    chk("throughput", n_hs, 16);

    // decode stalled: queue fills, issue stops, then drains in order
    set_mode(1, 1, 0, 100, 0);
    do_reset();
    repeat (12) cycle();
    chk("stall_accepts", n_acc, 4);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_out_valid", out_valid, 1);
    p_ordy = 100; out_ready = 1'b1; got_first = 1'b0; n_hs = 0;
    repeat (4) cycle();
    chk("drain_first_pc", first_pc, RST_PC);
    chk("drain_count", n_hs, 4);

    // redirect with three slow requests in flight
    set_mode(5, 5, 100, 100, 0);
    do_reset();
    repeat (3) cycle();
    chk("slow_accepts", n_acc, 3);
    inject_redirect(32'h0200_0003);
    got_first = 1'b0; n_drop = 0;
    for (int k = 0; k < 40 && !got_first; k++) cycle();
    chk("redir_got_first", got_first, 1);
    chk("redir_first_pc", first_pc, 32'h0200_0000);
    chk("redir_first_instr", first_instr, mem_word(32'h0200_0000));
    chk("redir_drops", n_drop, 3);

    // redirect coinciding with a response and a dequeue
    set_mode(1, 1, 100, 100, 0);
    do_reset();
    repeat (6) cycle();
    chk("coinc_rsp", imem_rsp_valid, 1);
    chk("coinc_out_valid", out_valid, 1);
    n_drop = 0;
    inject_redirect(32'h0300_0008);
    cycle();
    chk("coinc_empty_n1", out_valid, 0);
    chk("coinc_req_n1", imem_req_valid, 1);
    chk("coinc_addr_n1", imem_req_addr, 32'h0300_0008);
    cycle();
    chk("coinc_empty_n2", out_valid, 0);
    cycle();
    chk("coinc_valid_n3", out_valid, 1);
    chk("coinc_pc_n3", out_pc, 32'h0300_0008);
    repeat (4) cycle();
    chk("coinc_drops", n_drop, 1);

    // memory not ready: request held stable
    set_mode(1, 1, 100, 0, 0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk("hold_valid", imem_req_valid, 1);
      chk("hold_addr", imem_req_addr, RST_PC);
      cycle();
    end
    p_rrdy = 100; imem_req_ready = 1'b1;
    repeat (8) cycle();
    chk("hold_resume", n_acc > 4, 1);

    // reset asserted with a full queue
    set_mode(1, 1, 0, 100, 0);
    do_reset();
    repeat (10) cycle();
    chk("midrst_full", out_valid, 1);
    set_mode(1, 1, 100, 100, 0);
    do_reset();
    repeat (10) cycle();
    chk("midrst_restart_pc", first_pc, RST_PC);

    // random traffic with frequent and back-to-back redirects
    set_mode(1, 4, 70, 70, 6);
    do_reset();
    repeat (3000) cycle();
    chk("rand_progress", n_hs > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
